// File: rtl/shift_164_ctrl.sv
// shift_164_ctrl: sequencer that loads parallel words, MSB first, into a chain of
// cascaded 74164 serial-in/parallel-out shift registers. A word is taken over a
// valid/ready handshake. The chain's serial data, shift clock and master reset
// are generated from the system clock. done pulses once the chain holds the word,
// or once a clear of the chain has finished.
module shift_164_ctrl #(
  parameter int N_CHIPS = 1,
  parameter int CLKDIV  = 1
) (
  input  logic                 cp,
  input  logic                 n_mr,
  input  logic [8*N_CHIPS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 clr_req,
  output logic                 sr_ds,
  output logic                 sr_cp,
  output logic                 sr_n_mr,
  output logic                 busy,
  output logic                 done
);

  localparam int TOTAL = 8 * N_CHIPS;
  localparam int DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam logic [DW-1:0] DLAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BTOT  = BW'(TOTAL);
  localparam logic [BW-1:0] BONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [DW-1:0]    dcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic [TOTAL-1:0] sreg_q;
  logic             clr_pend_q;
  logic             sr_ds_q;
  logic             sr_cp_q;
  logic             sr_n_mr_q;
  logic             din_ready_q;
  logic             busy_q;
  logic             done_q;

  // The current phase of the shift clock or clear pulse has run its full length.
  logic             dlast_d;
  // A clear has been requested, either now or earlier during a transfer.
  logic             clr_pend_d;

  assign dlast_d    = (dcnt_q == DLAST);
  assign clr_pend_d = clr_pend_q | clr_req;

  // Sequencer FSM. Every chain-facing output is a register, so sr_cp cannot glitch.
  // sr_ds and sr_n_mr are only updated on edges where sr_cp stays low or falls.
  always_ff @(posedge cp or negedge n_mr) begin
    if (!n_mr) begin
      state_q     <= S_CLEAR;
      dcnt_q      <= '0;
      bcnt_q      <= '0;
      sreg_q      <= '0;
      clr_pend_q  <= 1'b0;
      sr_ds_q     <= 1'b0;
      sr_cp_q     <= 1'b0;
      sr_n_mr_q   <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A clear wins over a word offered in the same cycle. That word is
          // not taken, even though din_ready was high in this cycle.
          if (clr_pend_d) begin
            state_q     <= S_CLEAR;
            clr_pend_q  <= 1'b0;
            dcnt_q      <= '0;
            sr_n_mr_q   <= 1'b0;
            sr_cp_q     <= 1'b0;
            sr_ds_q     <= 1'b0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else if (din_valid) begin
            state_q     <= S_SETUP;
            sreg_q      <= din;
            bcnt_q      <= BTOT;
            dcnt_q      <= '0;
            sr_ds_q     <= din[TOTAL-1];
            din_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_SETUP: begin
          clr_pend_q <= clr_pend_d;
          sr_ds_q    <= sreg_q[TOTAL-1];
          if (dlast_d) begin
            dcnt_q  <= '0;
            sr_cp_q <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_HIGH: begin
          clr_pend_q <= clr_pend_d;
          if (dlast_d) begin
            dcnt_q  <= '0;
            sr_cp_q <= 1'b0;
            sreg_q  <= {sreg_q[TOTAL-2:0], 1'b0};
            bcnt_q  <= bcnt_q - BONE;
            if (bcnt_q == BONE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // The next bit is presented on the same edge where sr_cp falls.
              state_q <= S_SETUP;
              sr_ds_q <= sreg_q[TOTAL-2];
            end
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_CLEAR: begin
          // clr_req is absorbed here because the chain is already being cleared.
          if (dlast_d) begin
            dcnt_q    <= '0;
            sr_n_mr_q <= 1'b1;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end
        S_DONE: begin
          clr_pend_q  <= clr_pend_d;
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          din_ready_q <= ~clr_pend_d;
        end
        default: begin
          state_q     <= S_CLEAR;
          dcnt_q      <= '0;
          sr_n_mr_q   <= 1'b0;
          sr_cp_q     <= 1'b0;
          sr_ds_q     <= 1'b0;
          din_ready_q <= 1'b0;
          busy_q      <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready = din_ready_q;
  assign sr_ds     = sr_ds_q;
  assign sr_cp     = sr_cp_q;
  assign sr_n_mr   = sr_n_mr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
